// File: rtl/row_fetch_scheduler_pkg.sv
// row_fetch_scheduler_pkg: shared states and sizing constants for the row fetch scheduler
package row_fetch_scheduler_pkg;
    localparam int ROW_SLOTS     = 4;
    localparam int WORDS_PER_ROW = 4;
    localparam int MIN_ROWS      = 3;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROW, HOLD, FINISH} state_t;
endpackage

// File: rtl/row_fetch_scheduler_tracker.sv
// row_slot_tracker: head/tail/resident bookkeeping for the circular row RF slots
module row_slot_tracker
    import row_fetch_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic [2:0] resident,
    output logic [2:0] resident_nxt
);
    logic [1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0] resident_q, resident_d;
    logic       pop_ok, push_ok;
    always_comb begin
        pop_ok     = pop && resident_q != 3'd0;
        push_ok    = push && (resident_q < 3'(ROW_SLOTS) || pop_ok);
        head_d     = clear ? 2'd0 : head_q + {1'b0, pop_ok};
        tail_d     = clear ? 2'd0 : tail_q + {1'b0, push_ok};
        resident_d = clear ? 3'd0 : resident_q + {2'b0, push_ok} - {2'b0, pop_ok};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            resident_q <= 3'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            resident_q <= resident_d;
        end
    end
    assign head         = head_q;
    assign tail         = tail_q;
    assign resident     = resident_q;
    assign resident_nxt = resident_d;
endmodule

// File: rtl/row_fetch_scheduler.sv
// row_fetch_scheduler: fetches ifmap rows from DRAM into 4 row RFs and issues 3-row windows
module row_fetch_scheduler
    import row_fetch_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  img_rows,
    input  logic [15:0] base_addr,
    output logic        dram_req,
    output logic [15:0] dram_addr,
    input  logic        dram_ack,
    input  logic        row_done,
    output logic [1:0]  row_slot,
    output logic        win_valid,
    output logic [1:0]  win_base,
    input  logic        win_consume,
    output logic        busy,
    output logic        done,
    output logic        err
);
    state_t      state_q, state_d;
    logic [5:0]  rows_q, rows_d, fetch_row_q, fetch_row_d, win_cnt_q, win_cnt_d;
    logic [15:0] base_q, base_d, dram_addr_q, dram_addr_d;
    logic [1:0]  word_cnt_q, word_cnt_d;
    logic        dram_req_q, dram_req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        accept, push, pop, in_pass;
    logic [2:0]  resident, resident_nxt;
    assign in_pass   = state_q inside {FETCH, WAIT_ROW, HOLD};
    assign win_valid = in_pass && resident >= 3'(MIN_ROWS) && win_cnt_q < rows_q - 6'd2;
    assign accept    = start && state_q == IDLE;
    assign push      = row_done && state_q == WAIT_ROW;
    assign pop       = win_consume && win_valid;
    row_slot_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .push         (push),
        .pop          (pop),
        .head         (win_base),
        .tail         (row_slot),
        .resident     (resident),
        .resident_nxt (resident_nxt)
    );
    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        base_d      = base_q;
        fetch_row_d = fetch_row_q;
        word_cnt_d  = word_cnt_q;
        win_cnt_d   = win_cnt_q + {5'b0, pop};
        err_d       = err_q || (row_done && state_q != WAIT_ROW)
                            || (dram_ack && !dram_req_q && busy_q);
        if (accept) begin
            rows_d      = img_rows;
            base_d      = base_addr;
            fetch_row_d = 6'd0;
            word_cnt_d  = 2'd0;
            win_cnt_d   = 6'd0;
            state_d     = img_rows < 6'(MIN_ROWS) ? FINISH : FETCH;
        end else begin
            unique case (state_q)
                FETCH: if (dram_ack && dram_req_q) begin
                    word_cnt_d = word_cnt_q + 2'd1;
                    state_d    = word_cnt_q == 2'(WORDS_PER_ROW - 1) ? WAIT_ROW : FETCH;
                end
                WAIT_ROW: if (row_done) begin
                    fetch_row_d = fetch_row_q + 6'd1;
                    state_d     = (fetch_row_d < rows_q && resident_nxt < 3'(ROW_SLOTS)) ? FETCH : HOLD;
                end
                HOLD: state_d = (resident_nxt < 3'(ROW_SLOTS) && fetch_row_q < rows_q) ? FETCH : HOLD;
                FINISH: state_d = IDLE;
                default: state_d = state_q;
            endcase
            if (pop && win_cnt_d == rows_q - 6'd2)
                state_d = FINISH;
        end
        dram_req_d  = state_d == FETCH;
        dram_addr_d = dram_req_d ? base_d + {8'b0, fetch_row_d, word_cnt_d} : 16'd0;
        busy_d      = state_d inside {FETCH, WAIT_ROW, HOLD};
        done_d      = state_d == FINISH && state_q != FINISH;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_q      <= 6'd0;
            base_q      <= 16'd0;
            fetch_row_q <= 6'd0;
            word_cnt_q  <= 2'd0;
            win_cnt_q   <= 6'd0;
            dram_req_q  <= 1'b0;
            dram_addr_q <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            base_q      <= base_d;
            fetch_row_q <= fetch_row_d;
            word_cnt_q  <= word_cnt_d;
            win_cnt_q   <= win_cnt_d;
            dram_req_q  <= dram_req_d;
            dram_addr_q <= dram_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
    assign dram_req  = dram_req_q;
    assign dram_addr = dram_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
